// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude compare controller.
//   state_t : controller state encoding (IDLE / RUN / DONE)
//   SLICE_W : bit width of the compare slice stepped across the operands
package cmp_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_cmp_ctrl_if.sv
// Compare request/result bundle between the operand source and the controller.
//   start        : compare request, sampled on the rising clock edge
//   a, b         : unsigned operands, captured when start is accepted
//   busy         : compare in progress
//   done         : one-cycle pulse, result flags valid from this cycle on
//   a_gt_b/a_eq_b/a_lt_b : one-hot compare result
// Modports: master = requester, slave = serial_cmp_ctrl.
interface serial_cmp_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;

    modport master (
        output start, a, b,
        input  busy, done, a_gt_b, a_eq_b, a_lt_b
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_gt_b, a_eq_b, a_lt_b
    );
endinterface

// File: rtl/slice_cmp2.sv
// Combinational 2-bit unsigned compare slice.
//   x, y : 2-bit operand slices
//   gt   : x > y
//   eq   : x == y
//   lt   : x < y (neither gt nor eq)
module slice_cmp2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (x[1] & ~y[1])
              | (x[0] & ~y[1] & ~y[0])
              | (x[1] & x[0] & ~y[0]);
    assign eq = (x == y);
    assign lt = ~gt & ~eq;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Serial N-bit unsigned magnitude compare. One 2-bit slice is examined per
// cycle, MSB pair first; the walk stops at the first unequal pair.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : request/result bundle (slave side), see serial_cmp_ctrl_if
//
//   state | meaning
//   IDLE  | waiting for start, last result flags held
//   RUN   | stepping the slice index from MSB pair down
//   DONE  | one-cycle done pulse, result flags valid; start may re-arm
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_cmp_ctrl_if.slave    bus
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
            $error("serial_cmp_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [WIDTH-1:0]   a_r, a_nxt;
    logic [WIDTH-1:0]   b_r, b_nxt;
    logic               gt_q, gt_nxt;
    logic               eq_q, eq_nxt;
    logic               lt_q, lt_nxt;
    logic               busy_q, done_q;

    logic [SLICE_W-1:0] sx, sy;
    logic               s_gt, s_eq, s_lt;

    // Slice select: idx*2 as a bit offset into the captured operands.
    assign sx = a_r[{idx, 1'b0} +: SLICE_W];
    assign sy = b_r[{idx, 1'b0} +: SLICE_W];

    slice_cmp2 u_slice (
        .x  (sx),
        .y  (sy),
        .gt (s_gt),
        .eq (s_eq),
        .lt (s_lt)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        a_nxt     = a_r;
        b_nxt     = b_r;
        gt_nxt    = gt_q;
        eq_nxt    = eq_q;
        lt_nxt    = lt_q;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_nxt     = bus.a;
                    b_nxt     = bus.b;
                    idx_nxt   = IDX_W'(NSLICE - 1);
                    gt_nxt    = 1'b0;
                    eq_nxt    = 1'b0;
                    lt_nxt    = 1'b0;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (s_gt) begin
                    gt_nxt    = 1'b1;
                    state_nxt = DONE;
                end else if (s_lt) begin
                    lt_nxt    = 1'b1;
                    state_nxt = DONE;
                end else if (idx == '0) begin
                    eq_nxt    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx - IDX_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done come from their own flops, loaded from the next state,
    // so they are glitch-free and aligned with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            gt_q   <= 1'b0;
            eq_q   <= 1'b0;
            lt_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            a_r    <= a_nxt;
            b_r    <= b_nxt;
            gt_q   <= gt_nxt;
            eq_q   <= eq_nxt;
            lt_q   <= lt_nxt;
            busy_q <= (state_nxt == RUN);
            done_q <= (state_nxt == DONE);
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.a_gt_b = gt_q;
    assign bus.a_eq_b = eq_q;
    assign bus.a_lt_b = lt_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
module tb_serial_cmp_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_run;
    int   n_fail;

    serial_cmp_ctrl_if #(.WIDTH(8)) bus ();

    serial_cmp_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic  gt;
        logic  eq;
        logic  lt;
        int    done_cyc;
        string name;
    } exp_t;

    exp_t exp_q[$];

    // Stimulus drives right after a rising edge; acceptance is the next edge,
    // so done is visible k edges after that.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input int k,
                         input logic g, input logic e, input logic l, input string nm);
        exp_t x;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        x.gt = g; x.eq = e; x.lt = l;
        x.done_cyc = cyc + 1 + k;
        x.name = nm;
        exp_q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: {busy,done,gt,eq,lt} got %b want %b", nm, act, req);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.busy, bus.done, bus.a_gt_b, bus.a_eq_b, bus.a_lt_b};
    endfunction

    task automatic drain(input string nm);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL %s: timeout, %0d results outstanding, want 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            n_run++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, want no done", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({bus.a_gt_b, bus.a_eq_b, bus.a_lt_b} !== {e.gt, e.eq, e.lt} ||
                    cyc != e.done_cyc) begin
                    n_fail++;
                    $display("FAIL %s: flags gt/eq/lt %b%b%b at cycle %0d, want %b%b%b at cycle %0d",
                             e.name, bus.a_gt_b, bus.a_eq_b, bus.a_lt_b, cyc,
                             e.gt, e.eq, e.lt, e.done_cyc);
                end
            end
        end
    end

    initial begin
        n_run = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) step();
        check("reset_state", outs(), 5'b00000);
        rst_n = 1'b1;
        step();

        // 1: MSB slice decides, A > B
        issue(8'hC3, 8'h43, 1, 1'b1, 1'b0, 1'b0, "c1_gt");
        step();
        bus.start = 1'b0;
        check("c1_busy", outs(), 5'b10000);
        step();
        check("c1_done", outs(), 5'b01100);
        step();
        check("c1_after", outs(), 5'b00100);
        drain("c1");

        // 2: differs only in LSB pair, A < B
        step();
        issue(8'h12, 8'h13, 4, 1'b0, 1'b0, 1'b1, "c2_lt");
        step();
        bus.start = 1'b0;
        check("c2_busy", outs(), 5'b10000);
        drain("c2");

        // 3: equal operands, flags hold afterwards
        step();
        issue(8'hA5, 8'hA5, 4, 1'b0, 1'b1, 1'b0, "c3_eq");
        step();
        bus.start = 1'b0;
        drain("c3");
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("c3_hold%0d", i), outs(), 5'b00010);
        end

        // 4: start during RUN ignored
        issue(8'h00, 8'h01, 4, 1'b0, 1'b0, 1'b1, "c4_lt");
        step();
        bus.start = 1'b0;
        step();
        bus.start = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'h00;
        step();
        bus.start = 1'b0;
        drain("c4");

        // 5: reset mid-RUN abandons the compare
        step();
        issue(8'h01, 8'h02, 4, 1'b0, 1'b0, 1'b1, "c5_aborted");
        void'(exp_q.pop_back());
        step();
        bus.start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("c5_reset", outs(), 5'b00000);
        rst_n = 1'b1;
        repeat (6) step();
        check("c5_idle", outs(), 5'b00000);
        issue(8'h80, 8'h7F, 1, 1'b1, 1'b0, 1'b0, "c5_gt");
        step();
        bus.start = 1'b0;
        drain("c5");

        // 6: back-to-back, start held through the DONE cycle
        step();
        issue(8'hC3, 8'h43, 1, 1'b1, 1'b0, 1'b0, "c6_first");
        step();
        step();
        check("c6_done1", outs(), 5'b01100);
        issue(8'h00, 8'h40, 1, 1'b0, 1'b0, 1'b1, "c6_second");
        step();
        bus.start = 1'b0;
        check("c6_rearm", outs(), 5'b10000);
        drain("c6");
        step();
        check("c6_final", outs(), 5'b00001);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
